// File: rtl/riscv_pkg.sv
// Shared definitions for the memory pipeline stage.
// Contents:
//   - RV64 opcode constants
//   - access-size codes
//   - memory-stage FSM state enum
//   - helpers for misalignment detection, store strobes and store lane replication
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [0:0] {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  // An access is misaligned when the byte offset is not a multiple of its size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
    logic r;
    case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = a[0];
      SZ_W:    r = |a[1:0];
      SZ_D:    r = |a;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Byte strobes for an aligned store of the given size at offset a.
  function automatic logic [7:0] store_strobe(input logic [1:0] size, input logic [2:0] a);
    logic [7:0] r;
    case (size)
      SZ_B:    r = 8'h01 << a;
      SZ_H:    r = 8'h03 << a;
      SZ_W:    r = 8'h0F << a;
      SZ_D:    r = 8'hFF;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Low size bytes of the store data repeated across all eight lanes, so the
  // strobes alone pick the destination bytes.
  function automatic logic [63:0] store_lanes(input logic [1:0] size, input logic [63:0] d);
    logic [63:0] r;
    case (size)
      SZ_B:    r = {8{d[7:0]}};
      SZ_H:    r = {4{d[15:0]}};
      SZ_W:    r = {2{d[31:0]}};
      SZ_D:    r = d;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Bus bundle for the memory stage.
// Groups:
//   - MEM_* : input latch from execute
//   - DMEM_*: data-memory request/ack port
//   - V_MEM_STALL: upstream hold
//   - MEM_FE_*: fetch redirect
//   - WB_*  : write-back latch
// Modports:
//   - slave : the memory stage itself
//   - master: its environment (execute, data memory, fetch, write-back)
interface memory_stage_if;
  logic        MEM_V;
  logic [31:0] MEM_IR;
  logic [63:0] MEM_RES;
  logic [63:0] MEM_Address;
  logic [63:0] MEM_NPC;
  logic        MEM_PC_MUX;
  logic [63:0] MEM_Target_Address;
  logic [3:0]  MEM_Cst;

  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [63:0] DMEM_ADDR;
  logic [63:0] DMEM_WDATA;
  logic [7:0]  DMEM_WSTRB;
  logic        DMEM_ACK;
  logic [63:0] DMEM_RDATA;

  logic        V_MEM_STALL;
  logic        MEM_FE_BR_Taken;
  logic [63:0] MEM_FE_Target;

  logic        WB_V;
  logic [63:0] WB_RES;
  logic [4:0]  WB_DR;
  logic        WB_LD_REG;
  logic [31:0] WB_IR;
  logic [63:0] WB_NPC;
  logic [3:0]  WB_Cst;
  logic        WB_EXC;

  modport slave (
    input  MEM_V, MEM_IR, MEM_RES, MEM_Address, MEM_NPC, MEM_PC_MUX,
           MEM_Target_Address, MEM_Cst, DMEM_ACK, DMEM_RDATA,
    output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB,
           V_MEM_STALL, MEM_FE_BR_Taken, MEM_FE_Target,
           WB_V, WB_RES, WB_DR, WB_LD_REG, WB_IR, WB_NPC, WB_Cst, WB_EXC
  );

  modport master (
    output MEM_V, MEM_IR, MEM_RES, MEM_Address, MEM_NPC, MEM_PC_MUX,
           MEM_Target_Address, MEM_Cst, DMEM_ACK, DMEM_RDATA,
    input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_WSTRB,
           V_MEM_STALL, MEM_FE_BR_Taken, MEM_FE_Target,
           WB_V, WB_RES, WB_DR, WB_LD_REG, WB_IR, WB_NPC, WB_Cst, WB_EXC
  );
endinterface

// File: rtl/load_align.sv
// Load data alignment: selects the addressed bytes of a 64-bit read word and
// sign- or zero-extends them to 64 bits.
// Ports:
//   i_rdata    - doubleword read from memory
//   i_a        - byte offset within the doubleword
//   i_size     - access size code
//   i_unsigned - zero-extend instead of sign-extend
//   o_value    - extended load result
module load_align
  import riscv_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_a,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_value
);

  logic [63:0] w_shifted;

  // Bring the addressed lane down to bit 0, then extend by size.
  always_comb begin
    w_shifted = i_rdata >> {i_a, 3'b000};
    case (i_size)
      SZ_B:    o_value = i_unsigned ? {56'd0, w_shifted[7:0]}
                                    : {{56{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    o_value = i_unsigned ? {48'd0, w_shifted[15:0]}
                                    : {{48{w_shifted[15]}}, w_shifted[15:0]};
      SZ_W:    o_value = i_unsigned ? {32'd0, w_shifted[31:0]}
                                    : {{32{w_shifted[31]}}, w_shifted[31:0]};
      SZ_D:    o_value = w_shifted;
      default: o_value = w_shifted;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory-access pipeline stage.
// Behaviour:
//   - Runs a request/ack transaction with data memory for aligned loads and
//     stores, stalling upstream while it is outstanding.
//   - Aligns and extends load data.
//   - Forwards branch/jump redirects to fetch.
//   - Registers the write-back latch.
// Ports:
//   CLK   - rising-edge clock
//   RESET - asynchronous active-high reset
//   bus   - memory_stage_if.slave (MEM_* in, DMEM_* port, stall, redirect, WB_* out)
module memory_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic          CLK,
  input  logic          RESET,
  memory_stage_if.slave bus
);

  mem_state_e      r_state;
  mem_state_e      w_state_nxt;

  logic [6:0]      w_opcode;
  logic [1:0]      w_size;
  logic [2:0]      w_a;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_jump;
  logic            w_writes_rd;
  logic            w_misaligned;
  logic            w_mem_go;
  logic            w_exc;

  logic            w_stall;
  logic            w_issue;
  logic            w_ack;

  logic [XLEN-1:0] w_load_val;
  logic [63:0]     w_wb_res;
  logic            w_wb_ld_reg;

  logic            r_dmem_req;
  logic            r_dmem_we;
  logic [63:0]     r_dmem_addr;
  logic [63:0]     r_dmem_wdata;
  logic [7:0]      r_dmem_wstrb;

  logic            r_wb_v;
  logic [63:0]     r_wb_res;
  logic [4:0]      r_wb_dr;
  logic            r_wb_ld_reg;
  logic [31:0]     r_wb_ir;
  logic [63:0]     r_wb_npc;
  logic [3:0]      r_wb_cst;
  logic            r_wb_exc;

  // Instruction decode and misalignment check of the incoming latch.
  always_comb begin
    w_opcode     = bus.MEM_IR[6:0];
    w_size       = bus.MEM_IR[13:12];
    w_a          = bus.MEM_Address[2:0];
    w_is_load    = (w_opcode == OP_LOAD);
    w_is_store   = (w_opcode == OP_STORE);
    w_is_jump    = (w_opcode == OP_JAL) | (w_opcode == OP_JALR);
    w_misaligned = (w_is_load | w_is_store) & is_misaligned(w_size, w_a);
    w_mem_go     = bus.MEM_V & (w_is_load | w_is_store) & ~w_misaligned;
    w_exc        = bus.MEM_V & w_misaligned;
    case (w_opcode)
      OP_LOAD, OP_OP, OP_IMM, OP_OP32, OP_IMM32,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: w_writes_rd = 1'b1;
      default:                           w_writes_rd = 1'b0;
    endcase
  end

  // Redirects are independent of the memory FSM, so they are never stalled.
  assign bus.MEM_FE_BR_Taken = bus.MEM_V & (((w_opcode == OP_BRANCH) & bus.MEM_PC_MUX) | w_is_jump);
  assign bus.MEM_FE_Target   = bus.MEM_Target_Address;

  load_align u_load_align (
    .i_rdata    (bus.DMEM_RDATA),
    .i_a        (w_a),
    .i_size     (w_size),
    .i_unsigned (bus.MEM_IR[14]),
    .o_value    (w_load_val)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= MEM_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; an ACK seen in IDLE has no effect.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MEM_IDLE: begin
        if (w_mem_go) w_state_nxt = MEM_ACCESS;
        else          w_state_nxt = MEM_IDLE;
      end
      MEM_ACCESS: begin
        if (bus.DMEM_ACK) w_state_nxt = MEM_IDLE;
        else              w_state_nxt = MEM_ACCESS;
      end
      default: w_state_nxt = MEM_IDLE;
    endcase
  end

  // FSM outputs: stall is released in the ACK cycle so the next latch enters on that edge.
  always_comb begin
    w_stall = 1'b0;
    w_issue = 1'b0;
    w_ack   = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        w_stall = w_mem_go;
        w_issue = w_mem_go;
      end
      MEM_ACCESS: begin
        w_stall = ~bus.DMEM_ACK;
        w_ack   = bus.DMEM_ACK;
      end
      default: begin
        w_stall = 1'b0;
        w_issue = 1'b0;
        w_ack   = 1'b0;
      end
    endcase
  end

  assign bus.V_MEM_STALL = w_stall;

  // Write-back result selection.
  always_comb begin
    if (w_is_load & ~w_misaligned) begin
      w_wb_res = w_load_val;
    end else if (w_is_jump) begin
      w_wb_res = bus.MEM_NPC;
    end else begin
      w_wb_res = bus.MEM_RES;
    end
    w_wb_ld_reg = bus.MEM_V & w_writes_rd & (bus.MEM_IR[11:7] != 5'd0) & ~w_exc;
  end

  // Data-memory request registers; address/data/strobes stay stable through ACCESS.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 64'd0;
      r_dmem_wdata <= 64'd0;
      r_dmem_wstrb <= 8'd0;
    end else if (w_issue) begin
      r_dmem_req   <= 1'b1;
      r_dmem_we    <= w_is_store;
      r_dmem_addr  <= {bus.MEM_Address[63:3], 3'b000};
      r_dmem_wdata <= store_lanes(w_size, bus.MEM_RES);
      r_dmem_wstrb <= w_is_store ? store_strobe(w_size, w_a) : 8'h00;
    end else if (w_ack) begin
      r_dmem_req   <= 1'b0;
    end else begin
      r_dmem_req   <= r_dmem_req;
    end
  end

  // Write-back latch: a bubble on every stalled edge, otherwise capture the MEM latch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wb_v      <= 1'b0;
      r_wb_res    <= 64'd0;
      r_wb_dr     <= 5'd0;
      r_wb_ld_reg <= 1'b0;
      r_wb_ir     <= 32'd0;
      r_wb_npc    <= 64'd0;
      r_wb_cst    <= 4'd0;
      r_wb_exc    <= 1'b0;
    end else if (w_stall) begin
      r_wb_v      <= 1'b0;
    end else begin
      r_wb_v      <= bus.MEM_V;
      r_wb_res    <= w_wb_res;
      r_wb_dr     <= bus.MEM_IR[11:7];
      r_wb_ld_reg <= w_wb_ld_reg;
      r_wb_ir     <= bus.MEM_IR;
      r_wb_npc    <= bus.MEM_NPC;
      r_wb_cst    <= bus.MEM_Cst;
      r_wb_exc    <= w_exc;
    end
  end

  assign bus.DMEM_REQ   = r_dmem_req;
  assign bus.DMEM_WE    = r_dmem_we;
  assign bus.DMEM_ADDR  = r_dmem_addr;
  assign bus.DMEM_WDATA = r_dmem_wdata;
  assign bus.DMEM_WSTRB = r_dmem_wstrb;
  assign bus.WB_V       = r_wb_v;
  assign bus.WB_RES     = r_wb_res;
  assign bus.WB_DR      = r_wb_dr;
  assign bus.WB_LD_REG  = r_wb_ld_reg;
  assign bus.WB_IR      = r_wb_ir;
  assign bus.WB_NPC     = r_wb_npc;
  assign bus.WB_Cst     = r_wb_cst;
  assign bus.WB_EXC     = r_wb_exc;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios followed by random
// instruction streams, each compared against a transaction-level reference model.
module tb_memory_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  memory_stage_if bus ();

  memory_stage #(.XLEN(64)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
    return {17'd0, f3, rd, op};
  endfunction

  // Reference load: gather n bytes starting at offset a, then extend.
  function automatic logic [63:0] m_load(input logic [63:0] rd, input int a, input int n, input bit u);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (((rd >> (8 * (a + i))) & 64'hFF) << (8 * i));
    if (!u && n < 8 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  function automatic logic [7:0] m_strb(input int a, input int n);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < n; i++) s[a + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] d, input int n);
    logic [63:0] w;
    w = 64'd0;
    for (int lane = 0; lane < 8; lane++) w[8 * lane +: 8] = d[8 * (lane % n) +: 8];
    return w;
  endfunction

  // Present one MEM latch, play the memory side and check everything up to its WB.
  task automatic run_op(input logic v, input logic [31:0] ir, input logic [63:0] res,
                        input logic [63:0] addr, input logic [63:0] npc, input logic [63:0] tgt,
                        input logic pcmux, input logic [3:0] cst, input int ack_wait,
                        input logic [63:0] rdata, input logic idle_ack);
    logic [6:0]  op;
    int          n, a, stalls;
    bit          u, is_ld, is_st, mis, go, taken, ldreg;
    logic [63:0] exp_res;
    op    = ir[6:0];
    n     = 1 << ir[13:12];
    a     = int'(addr[2:0]);
    u     = ir[14];
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);
    mis   = (is_ld || is_st) && ((addr % 64'(n)) != 64'd0);
    go    = v && (is_ld || is_st) && !mis;
    taken = v && ((op == 7'b1100011 && pcmux) || op == 7'b1101111 || op == 7'b1100111);
    ldreg = (op inside {7'b0000011, 7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011,
                        7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111})
            && (ir[11:7] != 5'd0) && !mis;
    if (is_ld) exp_res = m_load(rdata, a, n, u);
    else if (op == 7'b1101111 || op == 7'b1100111) exp_res = npc;
    else exp_res = res;

    bus.MEM_V = v; bus.MEM_IR = ir; bus.MEM_RES = res; bus.MEM_Address = addr;
    bus.MEM_NPC = npc; bus.MEM_Target_Address = tgt; bus.MEM_PC_MUX = pcmux;
    bus.MEM_Cst = cst; bus.DMEM_ACK = idle_ack; bus.DMEM_RDATA = rdata ^ 64'hA5A5_5A5A_0F0F_F0F0;
    #1;
    check_val("br_taken", 64'(bus.MEM_FE_BR_Taken), 64'(taken));
    check_val("br_target", bus.MEM_FE_Target, tgt);
    check_val("stall_first", 64'(bus.V_MEM_STALL), 64'(go));

    if (go) begin
      stalls = 1;
      tick();
      bus.DMEM_ACK = 1'b0;
      check_val("req_issue", 64'(bus.DMEM_REQ), 64'd1);
      check_val("dmem_addr", bus.DMEM_ADDR, addr & ~64'd7);
      check_val("dmem_we", 64'(bus.DMEM_WE), 64'(is_st));
      check_val("wb_bubble", 64'(bus.WB_V), 64'd0);
      if (is_st) begin
        check_val("dmem_wstrb", 64'(bus.DMEM_WSTRB), 64'(m_strb(a, n)));
        check_val("dmem_wdata", bus.DMEM_WDATA, m_wdata(res, n));
      end
      for (int w = 0; w < ack_wait; w++) begin
        #1;
        if (bus.V_MEM_STALL) stalls++;
        tick();
        check_val("req_hold", 64'(bus.DMEM_REQ), 64'd1);
        check_val("addr_hold", bus.DMEM_ADDR, addr & ~64'd7);
        check_val("wb_wait", 64'(bus.WB_V), 64'd0);
      end
      bus.DMEM_ACK = 1'b1;
      bus.DMEM_RDATA = rdata;
      #1;
      check_val("stall_ack", 64'(bus.V_MEM_STALL), 64'd0);
      check_val("stall_count", 64'(stalls), 64'(ack_wait + 1));
      tick();
      bus.DMEM_ACK = 1'b0;
      check_val("req_drop", 64'(bus.DMEM_REQ), 64'd0);
    end else begin
      tick();
      bus.DMEM_ACK = 1'b0;
      check_val("no_req", 64'(bus.DMEM_REQ), 64'd0);
    end

    check_val("wb_v", 64'(bus.WB_V), 64'(v));
    if (v) begin
      check_val("wb_dr", 64'(bus.WB_DR), 64'(ir[11:7]));
      check_val("wb_ir", 64'(bus.WB_IR), 64'(ir));
      check_val("wb_npc", bus.WB_NPC, npc);
      check_val("wb_cst", 64'(bus.WB_Cst), 64'(cst));
      check_val("wb_exc", 64'(bus.WB_EXC), 64'(mis));
      check_val("wb_ld_reg", 64'(bus.WB_LD_REG), 64'(ldreg));
      if (!mis && !is_st) check_val("wb_res", bus.WB_RES, exp_res);
    end
  endtask

  logic [6:0] ops [12] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                           7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b0110111,
                           7'b0010111, 7'b0001111};

  initial begin
    logic [31:0] r32, ir;
    logic [63:0] addr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [1:0]  sz;

    bus.MEM_V = 1'b0; bus.MEM_IR = 32'd0; bus.MEM_RES = 64'd0; bus.MEM_Address = 64'd0;
    bus.MEM_NPC = 64'd0; bus.MEM_PC_MUX = 1'b0; bus.MEM_Target_Address = 64'd0;
    bus.MEM_Cst = 4'd0; bus.DMEM_ACK = 1'b0; bus.DMEM_RDATA = 64'd0;

    // Reset state
    #12;
    check_val("rst_req", 64'(bus.DMEM_REQ), 64'd0);
    check_val("rst_we", 64'(bus.DMEM_WE), 64'd0);
    check_val("rst_addr", bus.DMEM_ADDR, 64'd0);
    check_val("rst_wdata", bus.DMEM_WDATA, 64'd0);
    check_val("rst_wstrb", 64'(bus.DMEM_WSTRB), 64'd0);
    check_val("rst_wb_v", 64'(bus.WB_V), 64'd0);
    check_val("rst_wb_res", bus.WB_RES, 64'd0);
    check_val("rst_wb_dr", 64'(bus.WB_DR), 64'd0);
    check_val("rst_wb_ld", 64'(bus.WB_LD_REG), 64'd0);
    check_val("rst_wb_ir", 64'(bus.WB_IR), 64'd0);
    check_val("rst_wb_npc", bus.WB_NPC, 64'd0);
    check_val("rst_wb_cst", 64'(bus.WB_Cst), 64'd0);
    check_val("rst_wb_exc", 64'(bus.WB_EXC), 64'd0);
    rst = 1'b0;
    tick();

    // ADD
    run_op(1'b1, mk_ir(7'b0110011, 5'd5, 3'b000), 64'h1234, 64'h0, 64'h104, 64'h0, 1'b0, 4'h3, 0, 64'h0, 1'b0);
    check_val("add_res", bus.WB_RES, 64'h1234);
    // LB / LBU with two wait cycles
    run_op(1'b1, mk_ir(7'b0000011, 5'd7, 3'b000), 64'h0, 64'h1003, 64'h108, 64'h0, 1'b0, 4'h1, 2,
           64'h0000_0000_8000_0000, 1'b0);
    check_val("lb_res", bus.WB_RES, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(1'b1, mk_ir(7'b0000011, 5'd7, 3'b100), 64'h0, 64'h1003, 64'h10C, 64'h0, 1'b0, 4'h1, 2,
           64'h0000_0000_8000_0000, 1'b0);
    check_val("lbu_res", bus.WB_RES, 64'h80);
    // SH
    run_op(1'b1, mk_ir(7'b0100011, 5'd0, 3'b001), 64'hBEEF, 64'h2006, 64'h110, 64'h0, 1'b0, 4'h2, 0, 64'h0, 1'b0);
    // Misaligned LW, with a stray ACK in IDLE
    run_op(1'b1, mk_ir(7'b0000011, 5'd9, 3'b010), 64'h0, 64'h1002, 64'h114, 64'h0, 1'b0, 4'h0, 0, 64'h0, 1'b1);
    // BEQ taken, JAL
    run_op(1'b1, mk_ir(7'b1100011, 5'd0, 3'b000), 64'h1, 64'h0, 64'h118, 64'h400, 1'b1, 4'h0, 0, 64'h0, 1'b0);
    run_op(1'b1, mk_ir(7'b1101111, 5'd1, 3'b000), 64'h55, 64'h0, 64'h1004, 64'h800, 1'b0, 4'h0, 0, 64'h0, 1'b0);
    check_val("jal_res", bus.WB_RES, 64'h1004);

    // Reset in the middle of an access
    bus.MEM_V = 1'b1; bus.MEM_IR = mk_ir(7'b0000011, 5'd3, 3'b011); bus.MEM_Address = 64'h3000;
    bus.DMEM_ACK = 1'b0;
    tick();
    check_val("mid_req_on", 64'(bus.DMEM_REQ), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_val("mid_req_async", 64'(bus.DMEM_REQ), 64'd0);
    check_val("mid_wb_v", 64'(bus.WB_V), 64'd0);
    bus.MEM_V = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_op(1'b1, mk_ir(7'b0000011, 5'd3, 3'b011), 64'h0, 64'h3008, 64'h200, 64'h0, 1'b0, 4'h5, 1,
           64'hDEAD_BEEF_0123_4567, 1'b0);

    // Random instruction stream
    for (int k = 0; k < 400; k++) begin
      op = ops[$urandom_range(0, 11)];
      sz = 2'($urandom_range(0, 3));
      if (op == 7'b0000011) f3 = {(sz != 2'b11) ? 1'($urandom_range(0, 1)) : 1'b0, sz};
      else if (op == 7'b0100011) f3 = {1'b0, sz};
      else f3 = 3'($urandom_range(0, 7));
      r32 = $urandom();
      ir = {r32[31:15], f3, r32[11:7], op};
      addr = {$urandom(), $urandom()};
      if ($urandom_range(0, 2) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
      run_op(1'($urandom_range(0, 7) != 0), ir, {$urandom(), $urandom()}, addr,
             {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), $urandom_range(0, 3), {$urandom(), $urandom()},
             1'($urandom_range(0, 1)));
    end

    bus.MEM_V = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access pipeline stage directly downstream of `execute`; it consumes the `MEM_*` latch that `execute` produces. For loads and stores it runs a request/acknowledge transaction with the data memory. Load data is aligned and sign/zero-extended, and the stage stalls upstream while an access is outstanding. It forwards branch/jump redirects to fetch and registers the write-back latch (`WB_*`).

## Interface
Parameters:
- `XLEN`, 64: datapath width. Only 64 is supported.

Ports:
- `CLK` in 1: clock. All state updates on rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `MEM_V` in 1: latch valid.
- `MEM_IR` in 32: instruction.
- `MEM_RES` in 64: ALU result; store data for stores.
- `MEM_Address` in 64: effective byte address for loads and stores.
- `MEM_NPC` in 64: PC+4.
- `MEM_PC_MUX` in 1: branch condition true.
- `MEM_Target_Address` in 64: branch/jump target.
- `MEM_Cst` in 4: control store bits (unused here; passed to WB).
- `DMEM_REQ` out 1: memory request (registered).
- `DMEM_WE` out 1: write enable.
- `DMEM_ADDR` out 64: doubleword-aligned address, `{MEM_Address[63:3],3'b0}`.
- `DMEM_WDATA` out 64: store data replicated to lanes.
- `DMEM_WSTRB` out 8: byte strobes.
- `DMEM_ACK` in 1: access complete; `DMEM_RDATA` valid this cycle.
- `DMEM_RDATA` in 64: read data.
- `V_MEM_STALL` out 1: upstream must hold `MEM_*` latch (combinational).
- `MEM_FE_BR_Taken` out 1, `MEM_FE_Target` out 64: redirect to fetch (combinational).
- `WB_V` out 1, `WB_RES` out 64, `WB_DR` out 5, `WB_LD_REG` out 1, `WB_IR` out 32, `WB_NPC` out 64, `WB_Cst` out 4, `WB_EXC` out 1: write-back latch.

## Operation
- Decode from `MEM_IR[6:0]`:
  - LOAD is `0000011`. STORE is `0100011`. BRANCH is `1100011`. JAL is `1101111`. JALR is `1100111`.
  - Size comes from funct3 `MEM_IR[13:12]`: B/H/W/D. `MEM_IR[14]` selects unsigned load (LBU/LHU/LWU).
- Misalignment: `MEM_Address` modulo size ≠ 0. The access is not issued, and the result completes in one cycle with `WB_EXC=1`, `WB_LD_REG=0`.
- FSM:
  - IDLE: entered on reset.
  - If `MEM_V` and an aligned load/store is present, issue `DMEM_REQ=1` with addr/we/wdata/wstrb registered, then go to ACCESS.
  - Otherwise, latch WB directly.
  - ACCESS: hold `DMEM_*` stable until `DMEM_ACK`. On the ACK edge, latch WB and return to IDLE with `DMEM_REQ=0`.
- Store strobes and data:
  - Strobes: B→`1<<a[2:0]`, H→`3<<a[2:0]`, W→`0F<<a[2:0]`, D→`FF`.
  - `DMEM_WDATA` is the low size bytes of `MEM_RES` replicated across all lanes.
- Load: select the lane by `a[2:0]`, then sign-extend or zero-extend to 64. Result goes to `WB_RES`.
- Non-memory: `WB_RES=MEM_RES`. For JAL/JALR, `WB_RES=MEM_NPC`.
- `WB_LD_REG=1` for LOAD, OP, OP-IMM, OP-32, OP-IMM-32, LUI, AUIPC, JAL and JALR, when `WB_DR≠0` and no exception. Stores and branches give 0.
- Redirect:
  - `MEM_FE_BR_Taken = MEM_V & ((BRANCH & MEM_PC_MUX) | JAL | JALR)`.
  - `MEM_FE_Target = MEM_Target_Address`.
  - Redirects are never stalled, since they are not memory ops.
- `WB_DR = MEM_IR[11:7]`. `WB_IR`, `WB_NPC` and `WB_Cst` are copied from the latch.

## Timing
- Reset values: state IDLE, `DMEM_REQ=0`, `DMEM_WE=0`, `DMEM_ADDR=0`, `DMEM_WDATA=0`, `DMEM_WSTRB=0`, `WB_V=0`, `WB_RES=0`, `WB_DR=0`, `WB_LD_REG=0`, `WB_IR=0`, `WB_NPC=0`, `WB_Cst=0`, `WB_EXC=0`.
- Non-memory and misaligned ops: 1 cycle (latch→WB).
- Memory ops: minimum 2 cycles, for an ACK in the first ACCESS cycle. Each ACK wait cycle adds 1.
- `V_MEM_STALL = (IDLE & MEM_V & aligned mem op) | (ACCESS & ~DMEM_ACK)`.
  - It is deasserted in the ACK cycle, so the next instruction enters on that edge.
- `WB_V=0` (bubble) on every edge where `V_MEM_STALL=1`. `WB_V=MEM_V` otherwise.
- The ACK cycle and a new latch arrive back-to-back. The next memory op issues from IDLE the following cycle, so there is no overlap.
- `DMEM_ACK` seen while in IDLE is ignored.
- `RESET` during ACCESS: the request is dropped immediately (async). Memory must tolerate an abandoned request, and no WB is produced.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (`OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_JALR`, `OP_OP`, `OP_IMM`, `OP_OP32`, `OP_IMM32`, `OP_LUI`, `OP_AUIPC`)
  - size codes `SZ_B`/`SZ_H`/`SZ_W`/`SZ_D`
  - state enum `MEM_IDLE`/`MEM_ACCESS`
- One combinational sub-module, `load_align`: inputs `rdata`, `a[2:0]`, size, unsigned; output a 64-bit extended value.
- Store lane/strobe generation stays inline.

## Test plan
- ADD, `MEM_RES=0x1234`, `IR[11:7]=5`: next edge `WB_V=1`, `WB_RES=0x1234`, `WB_LD_REG=1`, `V_MEM_STALL=0`.
- LB, addr `0x1003`, `RDATA=0x00000000_80000000`, ACK after 2 wait cycles:
  - `DMEM_ADDR=0x1000`.
  - Stall lasts 3 cycles.
  - `WB_RES=0xFFFFFFFFFFFFFF80`. LBU gives `0x80`.
- SH, addr `0x2006`, `MEM_RES=0xBEEF`: `DMEM_WE=1`, `WSTRB=0xC0`, `WDATA=0xBEEFBEEFBEEFBEEF`, `WB_LD_REG=0`.
- LW at addr `0x1002`: no `DMEM_REQ`, `WB_EXC=1`, 1-cycle completion.
- BEQ with `PC_MUX=1`, target `0x400`: `MEM_FE_BR_Taken=1`, `MEM_FE_Target=0x400` in the same cycle. JAL gives `WB_RES=MEM_NPC`.
- Assert `RESET` mid-ACCESS: `DMEM_REQ` drops without a clock edge, `WB_V=0`, and a following LD completes normally.
